// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits
// Define UART_TX_BREAK_EN to add the i_break input and the line-break state.
module uart_tx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] din,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_break,
`endif
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [3:0]    BRK_LAST  = 4'(DATA_BITS + STOP_BITS + 1);
`endif

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 32) begin : g_bad_oversample
    $error("uart_tx_cfg: OVERSAMPLE=%0d outside 4..32", OVERSAMPLE);
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY_MODE=%0d outside 0..2", PARITY_MODE);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_TX_BREAK_EN
    BREAK,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;
`ifdef UART_TX_BREAK_EN
  logic                 brk_min;
  logic                 brk_hi;
`endif

  assign bit_end = baud_tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_min   <= 1'b0;
      brk_hi    <= 1'b0;
`endif
    end else begin
      o_tx_done <= 1'b0;
      if (baud_tick && state != IDLE) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
      end
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          o_tx     <= 1'b1;
`ifdef UART_TX_BREAK_EN
          if (i_break) begin
            state     <= BREAK;
            o_tx      <= 1'b0;
            o_tx_busy <= 1'b1;
            brk_min   <= 1'b0;
            brk_hi    <= 1'b0;
          end else if (start) begin
`else
          if (start) begin
`endif
            shreg     <= din;
            par_bit   <= (^din) ^ (PARITY_MODE == 2);
            state     <= START;
            o_tx      <= 1'b0;
            o_tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            o_tx  <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_MODE != 0) begin
                state <= PARITY;
                o_tx  <= par_bit;
              end else begin
                state <= STOP;
                o_tx  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shreg   <= shreg >> 1;
              o_tx    <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            o_tx  <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              state     <= IDLE;
              bit_cnt   <= '0;
              o_tx_busy <= 1'b0;
              o_tx_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        // Exit is only taken on a bit boundary once the minimum has fully elapsed.
        BREAK: begin
          if (bit_end) begin
            if (brk_hi) begin
              state     <= IDLE;
              bit_cnt   <= '0;
              o_tx_busy <= 1'b0;
            end else if (brk_min && !i_break) begin
              brk_hi <= 1'b1;
              o_tx   <= 1'b1;
            end else if (bit_cnt == BRK_LAST) begin
              brk_min <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
`endif
        default: begin
          state     <= IDLE;
          o_tx      <= 1'b1;
          o_tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
